// File: rtl/adc_pkt_rx.sv
// adc_pkt_rx: receive-side framer for the ADC capture pad stream.
// Registers the pads, frames packets and gaps, checks length, gap and the
// self-test counter pattern, and queues {last, data} beats to a valid/ready sink.
module adc_pkt_rx #(
  parameter int DW      = 18,
  parameter int FIFO_AW = 4,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DW-1:0]    adc_data,
  input  logic             adc_valid,
  input  logic             cfg_en,
  input  logic             cfg_self_test,
  input  logic [LEN_W-1:0] cfg_pkt_len,
  input  logic [7:0]       cfg_min_gap,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] len_err_cnt,
  output logic [CNT_W-1:0] data_err_cnt,
  output logic [CNT_W-1:0] gap_err_cnt,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RX, GAP} state_t;

  localparam int DEPTH = 1 << FIFO_AW;

  state_t             state, state_nxt;
  logic [DW-1:0]      in_d, hold_d, exp_d;
  logic               in_v, en_d, hold_v, seeded;
  logic [LEN_W-1:0]   beat_cnt;
  logic [7:0]         gap_cnt;
  logic               en_rise, active, beat;
  logic               wr_en, wr_last, pkt_done, gap_viol, len_bad, data_bad;
  logic [DW:0]        mem [0:DEPTH-1];
  logic [DW:0]        head;
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic               empty, full, push, pop, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The rising edge of cfg_en restarts the receiver; that cycle does no framing.
  assign en_rise = cfg_en & ~en_d;
  assign active  = cfg_en & ~en_rise;
  assign beat    = active & in_v;

  // Pad capture stage plus enable history for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_d <= '0;
      in_v <= 1'b0;
      en_d <= 1'b0;
    end else begin
      in_d <= adc_data;
      in_v <= adc_valid;
      en_d <= cfg_en;
    end
  end

  // Decide whether the held beat leaves this cycle and whether it closes a packet.
  always_comb begin
    wr_en   = 1'b0;
    wr_last = 1'b0;
    if (active) begin
      if (hold_v) begin
        wr_en   = 1'b1;
        wr_last = ~in_v;
      end
    end else if (!cfg_en && hold_v) begin
      wr_en   = 1'b1;
      wr_last = 1'b1;
    end
  end

  // One-beat hold register so a beat's last flag is known before it is queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_v <= 1'b0;
      hold_d <= '0;
    end else if (en_rise) begin
      hold_v <= 1'b0;
    end else if (beat) begin
      hold_v <= 1'b1;
      hold_d <= in_d;
    end else if (wr_last) begin
      hold_v <= 1'b0;
    end
  end

  // Framing FSM: next state plus packet-end and short-gap events.
  always_comb begin
    state_nxt = state;
    pkt_done  = 1'b0;
    gap_viol  = 1'b0;
    if (!active) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (in_v) state_nxt = RX;
        RX: if (!in_v) begin
          state_nxt = GAP;
          pkt_done  = 1'b1;
        end
        GAP: if (in_v) begin
          state_nxt = RX;
          gap_viol  = (gap_cnt < cfg_min_gap);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign len_bad  = pkt_done & (cfg_pkt_len != '0) & (beat_cnt != cfg_pkt_len);
  assign data_bad = beat & cfg_self_test & seeded & (in_d != exp_d);

  // FSM state register with per-packet beat and per-gap cycle counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        if (state == RX) beat_cnt <= (&beat_cnt) ? beat_cnt : beat_cnt + LEN_W'(1);
        else             beat_cnt <= LEN_W'(1);
      end
      if (pkt_done) gap_cnt <= 8'd1;
      else if (active && state == GAP && !in_v && gap_cnt != 8'hFF) gap_cnt <= gap_cnt + 8'd1;
    end
  end

  // Self-test tracker: every beat reseeds the expectation to data+1, wrapping at DW bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seeded <= 1'b0;
      exp_d  <= '0;
    end else if (en_rise) begin
      seeded <= 1'b0;
    end else if (beat && cfg_self_test) begin
      seeded <= 1'b1;
      exp_d  <= in_d + DW'(1);
    end
  end

  // Status counters and sticky overflow, restarted by an enable rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt      <= '0;
      len_err_cnt  <= '0;
      data_err_cnt <= '0;
      gap_err_cnt  <= '0;
      ovf          <= 1'b0;
    end else if (en_rise) begin
      pkt_cnt      <= '0;
      len_err_cnt  <= '0;
      data_err_cnt <= '0;
      gap_err_cnt  <= '0;
      ovf          <= 1'b0;
    end else begin
      if (pkt_done) pkt_cnt      <= sat_inc(pkt_cnt);
      if (len_bad)  len_err_cnt  <= sat_inc(len_err_cnt);
      if (data_bad) data_err_cnt <= sat_inc(data_err_cnt);
      if (gap_viol) gap_err_cnt  <= sat_inc(gap_err_cnt);
      if (drop)     ovf          <= 1'b1;
    end
  end

  // Show-ahead FIFO: a pop in the same cycle frees the slot a full push needs.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop   = m_valid & m_ready;
  assign push  = wr_en & (~full | pop);
  assign drop  = wr_en & full & ~pop;

  // FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {wr_last, hold_d};
  end

  // FIFO read and write pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head    = mem[rd_ptr[FIFO_AW-1:0]];
  assign m_valid = ~empty;
  assign m_data  = m_valid ? head[DW-1:0] : '0;
  assign m_last  = m_valid & head[DW];
  assign busy    = (state == RX);

endmodule

// File: tb/tb_adc_pkt_rx.sv
// tb_adc_pkt_rx: directed scoreboard bench for adc_pkt_rx.
module tb_adc_pkt_rx;

  logic        clk = 1'b0;
  logic        rstn;
  logic [17:0] adc_data;
  logic        adc_valid;
  logic        cfg_en;
  logic        cfg_self_test;
  logic [15:0] cfg_pkt_len;
  logic [7:0]  cfg_min_gap;
  logic [17:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] pkt_cnt, len_err_cnt, data_err_cnt, gap_err_cnt;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [18:0] expq[$];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  adc_pkt_rx #(.DW(18), .FIFO_AW(4), .LEN_W(16), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .adc_data(adc_data), .adc_valid(adc_valid),
    .cfg_en(cfg_en), .cfg_self_test(cfg_self_test), .cfg_pkt_len(cfg_pkt_len),
    .cfg_min_gap(cfg_min_gap), .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .pkt_cnt(pkt_cnt), .len_err_cnt(len_err_cnt),
    .data_err_cnt(data_err_cnt), .gap_err_cnt(gap_err_cnt), .ovf(ovf), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [17:0] d);
    @(posedge clk);
    #1;
    adc_valid = v;
    adc_data  = d;
  endtask

  task automatic pushBeat(input logic [17:0] d, input logic last, input logic keep);
    applyStimulus(1'b1, d);
    if (keep) expq.push_back({last, d});
  endtask

  task automatic sendGap(input int n);
    repeat (n) applyStimulus(1'b0, 18'h0);
  endtask

  task automatic sendPkt(input logic [17:0] first, input int n, input int gap);
    for (int i = 0; i < n; i++) pushBeat(18'(first + 18'(i)), (i == n - 1), 1'b1);
    sendGap(gap);
  endtask

  task automatic reEnable();
    @(posedge clk);
    #1 cfg_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 cfg_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((expq.size() != 0 || m_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_drain"}, 32'(n < 300), 32'd1);
  endtask

  task automatic checkCounters(input string tag, input int p, input int l, input int d, input int g);
    checkOutput({tag, "_pkt_cnt"},      32'(pkt_cnt),      32'(p));
    checkOutput({tag, "_len_err_cnt"},  32'(len_err_cnt),  32'(l));
    checkOutput({tag, "_data_err_cnt"}, 32'(data_err_cnt), 32'(d));
    checkOutput({tag, "_gap_err_cnt"},  32'(gap_err_cnt),  32'(g));
  endtask

  // Scoreboard: compare each accepted head beat against the oldest expected beat.
  task automatic runMonitor();
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (rstn && m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_beat", 32'({m_last, m_data}), 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          checkOutput("beat_data", 32'(m_data), 32'(e[17:0]));
          checkOutput("beat_last", 32'(m_last), 32'(e[18]));
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b1; adc_valid = 1'b0; adc_data = '0; cfg_en = 1'b1;
    cfg_self_test = 1'b1; cfg_pkt_len = 16'd4; cfg_min_gap = 8'd8; m_ready = 1'b1;
    fork
      runMonitor();
    join_none
    #1 rstn = 1'b0;
    #1;
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkCounters("rst", 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    $display("[TB] three clean packets");
    sendGap(3);
    for (int i = 0; i < 4; i++) pushBeat(18'(i), (i == 3), 1'b1);
    checkOutput("busy_in_pkt", 32'(busy), 32'd1);
    sendGap(15);
    sendPkt(18'd4, 4, 15);
    sendPkt(18'd8, 4, 15);
    waitDrain("clean");
    checkCounters("clean", 3, 0, 0, 0);
    checkOutput("clean_busy", 32'(busy), 32'd0);
    checkOutput("clean_ovf", 32'(ovf), 32'd0);

    $display("[TB] pattern skip, long packet, short gap");
    reEnable();
    checkCounters("cleared", 0, 0, 0, 0);
    sendPkt(18'd0, 4, 15);
    pushBeat(18'd4, 1'b0, 1'b1);
    for (int d = 6; d <= 9; d++) pushBeat(18'(d), (d == 9), 1'b1);
    sendGap(3);
    sendPkt(18'd10, 4, 15);
    waitDrain("errs");
    checkCounters("errs", 3, 1, 1, 1);

    $display("[TB] pattern wrap");
    reEnable();
    sendPkt(18'h3FFFE, 4, 15);
    waitDrain("wrap");
    checkCounters("wrap", 1, 0, 0, 0);

    $display("[TB] overflow under stall");
    reEnable();
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) pushBeat(18'(100 + i), 1'b0, (i < 16));
    sendGap(15);
    for (int k = 0; k < 4; k++) begin
      checkOutput("stall_m_valid", 32'(m_valid), 32'd1);
      checkOutput("stall_m_data", 32'(m_data), 32'd100);
      checkOutput("stall_m_last", 32'(m_last), 32'd0);
      sendGap(1);
    end
    checkOutput("stall_ovf", 32'(ovf), 32'd1);
    checkCounters("stall", 1, 1, 0, 0);
    m_ready = 1'b1;
    waitDrain("stall");
    checkOutput("stall_ovf_sticky", 32'(ovf), 32'd1);

    $display("[TB] enable dropped mid-packet");
    reEnable();
    checkOutput("reen_ovf_clear", 32'(ovf), 32'd0);
    pushBeat(18'd0, 1'b0, 1'b1);
    pushBeat(18'd1, 1'b0, 1'b1);
    pushBeat(18'd2, 1'b1, 1'b1);
    pushBeat(18'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cfg_en = 1'b0;
    adc_valid = 1'b0;
    sendGap(5);
    waitDrain("drop");
    checkCounters("drop", 0, 0, 0, 0);
    checkOutput("drop_busy", 32'(busy), 32'd0);

    $display("[TB] reset mid-packet");
    reEnable();
    for (int i = 0; i < 6; i++) pushBeat(18'(i), 1'b0, 1'b1);
    #3 rstn = 1'b0;
    #1;
    checkOutput("arst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("arst_m_data", 32'(m_data), 32'd0);
    checkOutput("arst_m_last", 32'(m_last), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkCounters("arst", 0, 0, 0, 0);
    expq.delete();
    adc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    sendGap(3);
    sendPkt(18'd0, 4, 15);
    waitDrain("post_rst");
    checkCounters("post_rst", 1, 0, 0, 0);
    checkOutput("post_rst_ovf", 32'(ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
